// File: rtl/dcache_wb_ctrl_if.sv
// Bundles the MEM-stage request port and the line-wide memory port of the data cache.
// The slave modport is the cache's view; the master modport is the pipeline/memory side.
interface dcache_wb_ctrl_if;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache with single-cycle hits.
// Misses stall the pipeline while the FSM writes back a dirty victim and refills the line.
module dcache_wb_ctrl #(
   parameter int INDEX_W  = 5,
   parameter int OFFSET_W = 5,
   parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   dcache_wb_ctrl_if.slave  bus
);
   localparam int LINES  = 1 << INDEX_W;
   localparam int LINE_W = 8 << OFFSET_W;
   localparam int WORD_W = OFFSET_W - 2;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_e;

   state_e              state_q, state_d;
   logic [LINES-1:0]    valid_q, dirty_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [LINE_W-1:0]   data_q [LINES];

   logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
   logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [TAG_W-1:0]    cpu_tag;
   logic [INDEX_W-1:0]  cpu_idx;
   logic [WORD_W-1:0]   cpu_word;
   logic                hit, store_hit, ack_ok, wb_done, fill_done, stall;
   logic                unused_addr_lsb;

   assign cpu_tag   = bus.cpu_addr_i[31 -: TAG_W];
   assign cpu_idx   = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
   assign cpu_word  = bus.cpu_addr_i[2 +: WORD_W];
   assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

   assign hit       = (state_q == S_IDLE) & bus.cpu_req_i & valid_q[cpu_idx] &
                      (tag_q[cpu_idx] == cpu_tag);
   assign store_hit = hit & bus.cpu_we_i;
   // An ack only counts while a request is outstanding; stray pulses are dropped.
   assign ack_ok    = bus.mem_ack_i & mem_req_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d     = state_q;
      miss_tag_d  = miss_tag_q;
      miss_idx_d  = miss_idx_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wb_done     = 1'b0;
      fill_done   = 1'b0;
      stall       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req_i && !hit) begin
               stall      = 1'b1;
               miss_tag_d = cpu_tag;
               miss_idx_d = cpu_idx;
               mem_req_d  = 1'b1;
               if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
                  state_d     = S_WRITEBACK;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {tag_q[cpu_idx], cpu_idx, {OFFSET_W{1'b0}}};
                  mem_wdata_d = data_q[cpu_idx];
               end else begin
                  state_d    = S_FILL;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
               end
            end
         end
         S_WRITEBACK: begin
            stall = 1'b1;
            if (ack_ok) begin
               wb_done    = 1'b1;
               state_d    = S_FILL;
               mem_we_d   = 1'b0;
               mem_addr_d = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
            end
         end
         S_FILL: begin
            stall = 1'b1;
            if (ack_ok) begin
               fill_done = 1'b1;
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_i) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         miss_tag_q  <= '0;
         miss_idx_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         miss_tag_q  <= miss_tag_d;
         miss_idx_q  <= miss_idx_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if (fill_done) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
         end else if (wb_done) begin
            dirty_q[miss_idx_q] <= 1'b0;
         end else if (store_hit) begin
            dirty_q[cpu_idx] <= 1'b1;
         end
      end
   end

   // NOTE: tag and data arrays carry no reset; valid_q alone qualifies their contents.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if (fill_done) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= bus.mem_rdata_i;
         end else if (store_hit) begin
            data_q[cpu_idx][{cpu_word, 5'b00000} +: 32] <= bus.cpu_wdata_i;
         end
      end
   end

   assign bus.cpu_rdata_o = hit ? data_q[cpu_idx][{cpu_word, 5'b00000} +: 32] : 32'h0;
   assign bus.cpu_stall_o = stall;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl: cold fill, hits, dirty eviction, write-allocate,
// zero-latency ack and reset during a fill, driven and sampled on the falling clock edge.
module tb_dcache_wb_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   stall_total = 0;
   int   base;
   logic [255:0] line;

   dcache_wb_ctrl_if bus ();

   dcache_wb_ctrl dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stall cycles are tallied mid-way through the low phase, after inputs settle.
   always @(negedge clk) begin
      #2;
      if (bus.cpu_stall_o === 1'b1) stall_total++;
   end

   // Memory contents: word i of line at address a holds a/4 + i.
   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = (a >> 2) + i;
      return l;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      bus.cpu_req_i   = req;
      bus.cpu_we_i    = we;
      bus.cpu_addr_i  = addr;
      bus.cpu_wdata_i = wdata;
   endtask

   // Called at the falling edge of the first request cycle; acks in request cycle lat
   // and returns at the falling edge of the cycle after the ack edge.
   task automatic serve(input int lat, input logic exp_we, input logic [31:0] exp_addr,
                        input string nm);
      for (int n = 1; n <= lat; n++) begin
         if (n > 1) @(negedge clk);
         check({nm, "_req"}, bus.mem_req_o, 1'b1);
         check({nm, "_we"}, bus.mem_we_o, exp_we);
         check({nm, "_addr"}, bus.mem_addr_o, exp_addr);
         check({nm, "_stall"}, bus.cpu_stall_o, 1'b1);
         if (n == lat) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = line_of(exp_addr);
         end
      end
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      repeat (2) @(negedge clk);
      check("rst_req", bus.mem_req_o, 1'b0);
      check("rst_we", bus.mem_we_o, 1'b0);
      check("rst_addr", bus.mem_addr_o, 32'h0);
      check("rst_wdata", bus.mem_wdata_o, 256'h0);
      check("rst_stall", bus.cpu_stall_o, 1'b0);
      check("rst_rdata", bus.cpu_rdata_o, 32'h0);
      rst_n = 1'b1;

      // Cold load, ack in the third request cycle
      @(negedge clk);
      base = stall_total;
      drive(1'b1, 1'b0, 32'h0000_0404, 32'h0);
      #1;
      check("cold_stall_comb", bus.cpu_stall_o, 1'b1);
      check("cold_req_same_cycle", bus.mem_req_o, 1'b0);
      @(negedge clk);
      serve(3, 1'b0, 32'h0000_0400, "cold");
      #1;
      check("cold_stall_drop", bus.cpu_stall_o, 1'b0);
      check("cold_rdata", bus.cpu_rdata_o, 32'h101);
      check("cold_stall_len", stall_total - base, 4);
      check("cold_req_done", bus.mem_req_o, 1'b0);

      // Back-to-back hits over the whole line
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 32'h400 + 4 * i, 32'h0);
         #1;
         check($sformatf("hit%0d_stall", i), bus.cpu_stall_o, 1'b0);
         check($sformatf("hit%0d_rdata", i), bus.cpu_rdata_o, 32'h100 + i);
         check($sformatf("hit%0d_req", i), bus.mem_req_o, 1'b0);
      end

      // Store hit, then a conflicting load forces a dirty eviction
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF);
      #1;
      check("st_hit_stall", bus.cpu_stall_o, 1'b0);
      @(negedge clk);
      base = stall_total;
      drive(1'b1, 1'b0, 32'h0000_0808, 32'h0);
      #1;
      check("evict_stall_comb", bus.cpu_stall_o, 1'b1);
      @(negedge clk);
      line = bus.mem_wdata_o;
      check("evict_wdata_w2", line[95:64], 32'hDEAD_BEEF);
      check("evict_wdata_w0", line[31:0], 32'h100);
      serve(2, 1'b1, 32'h0000_0400, "evict_wb");
      serve(2, 1'b0, 32'h0000_0800, "evict_fill");
      #1;
      check("evict_stall_drop", bus.cpu_stall_o, 1'b0);
      check("evict_rdata", bus.cpu_rdata_o, 32'h202);
      check("evict_stall_len", stall_total - base, 5);
      check("evict_req_done", bus.mem_req_o, 1'b0);

      // Store miss on a clean line: fill only, then the store lands
      @(negedge clk);
      base = stall_total;
      drive(1'b1, 1'b1, 32'h0000_0C10, 32'h1234_5678);
      #1;
      check("stmiss_stall_comb", bus.cpu_stall_o, 1'b1);
      @(negedge clk);
      serve(2, 1'b0, 32'h0000_0C00, "stmiss_fill");
      #1;
      check("stmiss_stall_drop", bus.cpu_stall_o, 1'b0);
      check("stmiss_stall_len", stall_total - base, 3);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0C10, 32'h0);
      #1;
      check("stmiss_ld_stall", bus.cpu_stall_o, 1'b0);
      check("stmiss_ld_rdata", bus.cpu_rdata_o, 32'h1234_5678);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0C14, 32'h0);
      #1;
      check("stmiss_ld_w5", bus.cpu_rdata_o, 32'h305);

      // Zero-latency fill on a cold index
      @(negedge clk);
      base = stall_total;
      drive(1'b1, 1'b0, 32'h0000_1024, 32'h0);
      @(negedge clk);
      serve(1, 1'b0, 32'h0000_1020, "zlat");
      #1;
      check("zlat_stall_drop", bus.cpu_stall_o, 1'b0);
      check("zlat_rdata", bus.cpu_rdata_o, 32'h409);
      check("zlat_stall_len", stall_total - base, 2);

      // The write-allocated line is dirty and gets written back on eviction
      @(negedge clk);
      base = stall_total;
      drive(1'b1, 1'b0, 32'h0000_0410, 32'h0);
      @(negedge clk);
      line = bus.mem_wdata_o;
      check("stdirty_wdata_w4", line[159:128], 32'h1234_5678);
      check("stdirty_wdata_w5", line[191:160], 32'h305);
      serve(1, 1'b1, 32'h0000_0C00, "stdirty_wb");
      serve(2, 1'b0, 32'h0000_0400, "stdirty_fill");
      #1;
      check("stdirty_rdata", bus.cpu_rdata_o, 32'h104);
      check("stdirty_stall_len", stall_total - base, 4);

      // Reset while a fill is outstanding, then a late ack
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_2040, 32'h0);
      @(negedge clk);
      check("rfill_req_before", bus.mem_req_o, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0000_2040, 32'h0);
      #1;
      check("rfill_req_after", bus.mem_req_o, 1'b0);
      check("rfill_stall_after", bus.cpu_stall_o, 1'b0);
      @(negedge clk);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = {256{1'b1}};
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      #1;
      check("late_ack_req", bus.mem_req_o, 1'b0);
      check("late_ack_stall", bus.cpu_stall_o, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0410, 32'h0);
      #1;
      check("post_rst_miss0", bus.cpu_stall_o, 1'b1);
      @(negedge clk);
      serve(1, 1'b0, 32'h0000_0400, "post_rst_fill0");
      #1;
      check("post_rst_rdata0", bus.cpu_rdata_o, 32'h104);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_2040, 32'h0);
      #1;
      check("post_rst_miss2", bus.cpu_stall_o, 1'b1);
      @(negedge clk);
      serve(1, 1'b0, 32'h0000_2040, "post_rst_fill2");
      #1;
      check("post_rst_rdata2", bus.cpu_rdata_o, 32'h810);
      check("post_rst_stall2", bus.cpu_stall_o, 1'b0);

      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_wb_ctrl.md
Name: dcache_wb_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and a line-wide off-chip data memory.
- Replaces the direct MEM-stage connection to the data memory.
- Hits complete in the same cycle with no stall.
- Misses assert a pipeline stall while an FSM writes back a dirty victim and refills the line over a req/ack handshake.

Parameters:
- INDEX_W, 5, index bits; LINES = 2^INDEX_W = 32
- OFFSET_W, 5, byte-offset bits; line = 32 bytes = 256 bits, 8 words
- TAG_W, 22, tag bits = 32 - INDEX_W - OFFSET_W

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-low
- cpu_req_i  in  1  MEM-stage load/store valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address; [1:0] ignored
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data, valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0
- cpu_stall_o  out  1  freezes PC and all pipeline buffers
- mem_req_o  out  1  memory request, held until acknowledged
- mem_we_o  out  1  1 = line write-back, 0 = line fill
- mem_addr_o  out  32  line address, [4:0] = 0
- mem_wdata_o  out  256  victim line
- mem_rdata_i  in  256  fill line, valid in the cycle mem_ack_i=1
- mem_ack_i  in  1  single-cycle completion pulse, one per transaction

Behaviour:
- Address split:
  - tag = addr[31:10]
  - index = addr[9:5]
  - word = addr[4:2], selects mem bits [32*word+31 : 32*word]
- Storage: per line valid bit, dirty bit, TAG_W tag and 256-bit data.
  - valid and dirty are reset.
  - Tag and data arrays are not reset.
- hit = cpu_req_i & valid[index] & (tag_array[index] == tag), evaluated combinationally in IDLE only.
- Reset (rst_i=0 at an edge):
  - state = IDLE; all valid = 0 and all dirty = 0
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0
  - cpu_rdata_o = 0 when no hit
- Reset mid-transaction: the FSM aborts to IDLE and mem_req_o is 0 from the next cycle. The in-flight line is discarded, and any ack arriving later is ignored.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - No request: cpu_stall_o = 0.
  - Load hit: cpu_rdata_o = selected word (combinational); stall = 0.
  - Store hit: the word is written at the edge and dirty[index] = 1; stall = 0.
  - Miss: cpu_stall_o = 1 combinationally in the same cycle. At the edge:
    - Latch addr, we and wdata.
    - If valid & dirty: go to WRITEBACK. mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line.
    - Otherwise: go to FILL. mem_req_o = 1, mem_we_o = 0, mem_addr_o = {latched tag, index, 5'b0}.
- WRITEBACK: stall = 1; outputs held stable until mem_ack_i = 1. At the ack edge:
  - dirty[index] = 0; go to FILL.
  - mem_req_o stays 1; mem_we_o = 0 and mem_addr_o = fill address from that edge.
  - Memory treats each ack as ending exactly one transaction.
- FILL: stall = 1; held until mem_ack_i = 1. At the ack edge:
  - data[index] = mem_rdata_i, tag[index] = latched tag, valid = 1, dirty = 0.
  - mem_req_o = 0; go to IDLE.
- Re-entry to IDLE: the access re-evaluates as a hit. The load returns data or the store writes and sets dirty, so stall drops in that cycle.
- Stall length:
  - Clean miss: 1 + Lf cycles.
  - Dirty miss: 1 + Lw + Lf cycles.
  - Lx = number of cycles mem_req_o is high for that transaction, including the ack cycle. Minimum Lx = 1; ack may arrive in the first req cycle.
- Ack handling: mem_ack_i while mem_req_o = 0 is ignored.
- CPU inputs: may change during stall. The FSM uses latched values. The final IDLE hit uses live inputs, which the pipeline holds frozen by cpu_stall_o.
- Stores never go to memory directly; write-back only on eviction.

Test Plan:
- Cold load, memory ack on 3rd req cycle:
  - Stimulus: load 0x0000_0404 after reset; line 0x400 in memory holds words 0..7 = 0x100..0x107.
  - Required: stall high exactly 4 cycles; one fill with mem_addr_o = 0x0000_0400, mem_we_o = 0; then cpu_rdata_o = 0x101 with stall = 0.
- Hit sequence:
  - Stimulus: loads of 0x400..0x41C back-to-back after the fill.
  - Required: no stall; rdata 0x100..0x107; mem_req_o stays 0.
- Store hit then dirty eviction:
  - Stimulus: store 0xDEADBEEF to 0x408, then load 0x0000_0808 (same index 0, different tag).
  - Required: write-back first, mem_addr_o = 0x400 and mem_wdata_o word 2 = 0xDEADBEEF; then fill of 0x800, mem_req_o continuous between them; stall = 1 + Lw + Lf.
- Store miss (write-allocate):
  - Stimulus: store 0x12345678 to clean-missing 0x0000_0C10.
  - Required: fill only, no write-back; the line is then dirty with word 4 = 0x12345678; a later load of 0xC10 hits with 0x12345678.
- Zero-latency ack:
  - Stimulus: mem_ack_i = 1 in the first req cycle of a fill.
  - Required: stall high exactly 2 cycles; correct data returned.
- Reset mid-fill:
  - Stimulus: rst_i = 0 for one edge while in FILL; a late ack is then pulsed.
  - Required: mem_req_o = 0 the next cycle; the late ack is ignored; a load to the same address misses again (valid cleared).
